// File: rtl/cdec8_ctrl.sv
// CDEC8 hardwired control unit: sequences fetch/decode/execute and run/step/halt.
// Optional feature macro: CDEC_ICOUNT_EN (retired-instruction counter on icount).
module cdec8_ctrl #(
    parameter logic [4:0] ALUOP_NOP = 5'h00,
    parameter logic [4:0] ALUOP_INC = 5'h01,
    parameter logic [4:0] ALUOP_ADD = 5'h02,
    parameter logic [4:0] ALUOP_SUB = 5'h03,
    parameter logic [4:0] ALUOP_AND = 5'h04,
    parameter logic [4:0] ALUOP_OR  = 5'h05
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [7:0]  I,
    input  logic [2:0]  SZCy,
    output logic [16:0] ctrl,
    output logic [7:0]  state,
    output logic        halted,
    output logic [7:0]  icount
);

    // Bus codes; source and destination spaces overlap on some values (R/MAR, RDR/WDR).
    localparam logic [3:0] X_PC   = 4'h0;
    localparam logic [3:0] X_R    = 4'h4;
    localparam logic [3:0] X_MAR  = 4'h4;
    localparam logic [3:0] X_RDR  = 4'h5;
    localparam logic [3:0] X_WDR  = 4'h5;
    localparam logic [3:0] X_T    = 4'h6;
    localparam logic [3:0] X_I    = 4'h7;
    localparam logic [3:0] X_IO   = 4'h8;
    localparam logic [3:0] X_NONE = 4'hF;

    typedef enum logic [7:0] {
        S_HALT = 8'h00, S_F0 = 8'h01, S_F1 = 8'h02, S_F2 = 8'h03,
        S_EX   = 8'h10, S_A1 = 8'h11, S_A2 = 8'h12,
        S_O1   = 8'h21, S_O2 = 8'h22, S_L1 = 8'h23, S_L2 = 8'h24,
        S_S1   = 8'h25, S_S2 = 8'h26
    } state_t;

    function automatic logic [3:0] reg_code(input logic [1:0] rr);
        case (rr)
            2'b00:   reg_code = 4'h1;
            2'b01:   reg_code = 4'h2;
            2'b10:   reg_code = 4'h3;
            default: reg_code = X_PC;
        endcase
    endfunction

    function automatic logic [4:0] alu_code(input logic [1:0] f);
        case (f)
            2'b00:   alu_code = ALUOP_ADD;
            2'b01:   alu_code = ALUOP_SUB;
            2'b10:   alu_code = ALUOP_AND;
            default: alu_code = ALUOP_OR;
        endcase
    endfunction

    function automatic logic cond_taken(input logic [1:0] cc, input logic [2:0] fl);
        case (cc)
            2'b00:   cond_taken = 1'b1;
            2'b01:   cond_taken = fl[1];
            2'b10:   cond_taken = fl[0];
            default: cond_taken = fl[2];
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        run_q;
    logic        stepm_q, stepm_d;
    logic        done_s, halt_s, taken_s;
    logic [3:0]  rd_s, rs_s;
    logic [4:0]  alu_f_s;
    logic [1:0]  mmrw_s;
    logic        fwr_s, rwr_s;
    logic [3:0]  xdst_s, xsrc_s;
    logic [4:0]  aluop_s;

    assign rd_s    = reg_code(I[3:2]);
    assign rs_s    = reg_code(I[1:0]);
    assign alu_f_s = alu_code(I[5:4]);
    assign taken_s = cond_taken(I[5:4], SZCy);

    // Next-state and control-word decode from the registered state and I.
    always_comb begin
        state_d = state_q;
        stepm_d = stepm_q;
        done_s  = 1'b0;
        halt_s  = 1'b0;
        mmrw_s  = 2'b00;
        fwr_s   = 1'b0;
        rwr_s   = 1'b0;
        xdst_s  = X_NONE;
        aluop_s = ALUOP_NOP;
        xsrc_s  = X_NONE;
        case (state_q)
            S_HALT: begin
                if (step) begin
                    state_d = S_F0;
                    stepm_d = 1'b1;
                end else if (run && !run_q) begin
                    state_d = S_F0;
                    stepm_d = 1'b0;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_F0: begin
                xsrc_s = X_PC; xdst_s = X_MAR; aluop_s = ALUOP_INC; rwr_s = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                mmrw_s = 2'b10; xsrc_s = X_R; xdst_s = X_PC;
                state_d = S_F2;
            end
            S_F2: begin
                xsrc_s = X_RDR; xdst_s = X_I;
                state_d = S_EX;
            end
            S_EX: begin
                case (I[7:6])
                    2'b00: begin
                        xsrc_s = rd_s; xdst_s = X_T;
                        state_d = S_A1;
                    end
                    2'b01: begin
                        done_s = 1'b1;
                        case (I[5:4])
                            2'b00:   begin xsrc_s = rs_s; xdst_s = rd_s; end
                            2'b01:   begin xsrc_s = X_IO; xdst_s = rd_s; end
                            2'b10:   begin xsrc_s = rs_s; xdst_s = X_IO; end
                            default: halt_s = 1'b1;
                        endcase
                    end
                    default: begin
                        xsrc_s = X_PC; xdst_s = X_MAR; aluop_s = ALUOP_INC; rwr_s = 1'b1;
                        state_d = S_O1;
                    end
                endcase
            end
            S_A1: begin
                xsrc_s = rs_s; aluop_s = alu_f_s; rwr_s = 1'b1; fwr_s = 1'b1;
                state_d = S_A2;
            end
            S_A2: begin
                xsrc_s = X_R; xdst_s = rd_s; done_s = 1'b1;
            end
            S_O1: begin
                mmrw_s = 2'b10; xsrc_s = X_R; xdst_s = X_PC;
                state_d = S_O2;
            end
            S_O2: begin
                if (I[6]) begin
                    // Jump: operand byte is consumed whether or not the branch is taken.
                    done_s = 1'b1;
                    if (taken_s) begin
                        xsrc_s = X_RDR; xdst_s = X_PC;
                    end else begin
                        xsrc_s = X_NONE; xdst_s = X_NONE;
                    end
                end else begin
                    case (I[5:4])
                        2'b00:   begin xsrc_s = X_RDR; xdst_s = X_MAR; state_d = S_L1; end
                        2'b01:   begin xsrc_s = X_RDR; xdst_s = X_MAR; state_d = S_S1; end
                        default: begin xsrc_s = X_RDR; xdst_s = rd_s; done_s = 1'b1; end
                    endcase
                end
            end
            S_L1: begin
                mmrw_s = 2'b10;
                state_d = S_L2;
            end
            S_L2: begin
                xsrc_s = X_RDR; xdst_s = rd_s; done_s = 1'b1;
            end
            S_S1: begin
                xsrc_s = rs_s; xdst_s = X_WDR;
                state_d = S_S2;
            end
            S_S2: begin
                mmrw_s = 2'b01; done_s = 1'b1;
            end
            default: state_d = S_HALT;
        endcase
        // A step-entered instruction always returns to HALT, as does the HALT opcode.
        state_d = done_s ? ((run && !stepm_q && !halt_s) ? S_F0 : S_HALT) : state_d;
    end

    // State register, run edge detector and entry-cause flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_HALT;
            run_q   <= 1'b0;
            stepm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run;
            stepm_q <= stepm_d;
        end
    end

    assign ctrl   = {mmrw_s, fwr_s, rwr_s, xdst_s, aluop_s, xsrc_s};
    assign state  = state_q;
    assign halted = (state_q == S_HALT);

`ifdef CDEC_ICOUNT_EN
    logic [7:0] icount_q;

    // Retired-instruction counter, wraps naturally at 8 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icount_q <= 8'h00;
        end else if (done_s) begin
            icount_q <= icount_q + 8'h01;
        end else begin
            icount_q <= icount_q;
        end
    end

    assign icount = icount_q;
`else
    assign icount = 8'h00;
`endif

endmodule

// File: tb/tb_cdec8_ctrl.sv
// Self-checking bench for cdec8_ctrl: instruction-level reference model, random programs.
module tb_cdec8_ctrl;

    logic        clock;
    logic        reset;
    logic        run;
    logic        step;
    logic [7:0]  I;
    logic [2:0]  SZCy;
    logic [16:0] ctrl;
    logic [7:0]  state;
    logic        halted;
    logic [7:0]  icount;

    int vectors;
    int miscompares;
    int retired;

    localparam logic [16:0] IDLE = 17'b00_0_0_1111_00000_1111;

    cdec8_ctrl dut (
        .clock  (clock),
        .reset  (reset),
        .run    (run),
        .step   (step),
        .I      (I),
        .SZCy   (SZCy),
        .ctrl   (ctrl),
        .state  (state),
        .halted (halted),
        .icount (icount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [16:0] cw(input logic [1:0] mm, input logic fw, input logic rw,
                                       input logic [3:0] xd, input logic [4:0] op,
                                       input logic [3:0] xs);
        return {mm, fw, rw, xd, op, xs};
    endfunction

    function automatic logic [3:0] rc(input logic [1:0] rr);
        return (rr == 2'd3) ? 4'd0 : ({2'b00, rr} + 4'd1);
    endfunction

    function automatic logic [7:0] exp_ic();
`ifdef CDEC_ICOUNT_EN
        return retired[7:0];
`else
        return 8'h00;
`endif
    endfunction

    // Runs one instruction from F0; poke 1 drops run in F0, poke 2 raises run and step mid-way.
    task automatic drive_instr(input logic [7:0] ins, input logic [2:0] fl, input int poke);
        logic [24:0] seq[$];
        logic [1:0]  op, f;
        logic [3:0]  rd, rs;
        logic        tk;
        op = ins[7:6]; f = ins[5:4]; rd = rc(ins[3:2]); rs = rc(ins[1:0]);
        seq.push_back({8'h01, cw(2'b00, 1'b0, 1'b1, 4'd4, 5'd1, 4'd0)});
        seq.push_back({8'h02, cw(2'b10, 1'b0, 1'b0, 4'd0, 5'd0, 4'd4)});
        seq.push_back({8'h03, cw(2'b00, 1'b0, 1'b0, 4'd7, 5'd0, 4'd5)});
        if (op == 2'd0) begin
            seq.push_back({8'h10, cw(2'b00, 1'b0, 1'b0, 4'd6, 5'd0, rd)});
            seq.push_back({8'h11, cw(2'b00, 1'b1, 1'b1, 4'd15, 5'd2 + {3'b000, f}, rs)});
            seq.push_back({8'h12, cw(2'b00, 1'b0, 1'b0, rd, 5'd0, 4'd4)});
        end else if (op == 2'd1) begin
            if (f == 2'd0)      seq.push_back({8'h10, cw(2'b00, 1'b0, 1'b0, rd, 5'd0, rs)});
            else if (f == 2'd1) seq.push_back({8'h10, cw(2'b00, 1'b0, 1'b0, rd, 5'd0, 4'd8)});
            else if (f == 2'd2) seq.push_back({8'h10, cw(2'b00, 1'b0, 1'b0, 4'd8, 5'd0, rs)});
            else                seq.push_back({8'h10, IDLE});
        end else begin
            seq.push_back({8'h10, cw(2'b00, 1'b0, 1'b1, 4'd4, 5'd1, 4'd0)});
            seq.push_back({8'h21, cw(2'b10, 1'b0, 1'b0, 4'd0, 5'd0, 4'd4)});
            if (op == 2'd3) begin
                tk = (f == 2'd0) ? 1'b1 : (f == 2'd1) ? fl[1] : (f == 2'd2) ? fl[0] : fl[2];
                seq.push_back({8'h22, tk ? cw(2'b00, 1'b0, 1'b0, 4'd0, 5'd0, 4'd5) : IDLE});
            end else if (f == 2'd0) begin
                seq.push_back({8'h22, cw(2'b00, 1'b0, 1'b0, 4'd4, 5'd0, 4'd5)});
                seq.push_back({8'h23, cw(2'b10, 1'b0, 1'b0, 4'd15, 5'd0, 4'd15)});
                seq.push_back({8'h24, cw(2'b00, 1'b0, 1'b0, rd, 5'd0, 4'd5)});
            end else if (f == 2'd1) begin
                seq.push_back({8'h22, cw(2'b00, 1'b0, 1'b0, 4'd4, 5'd0, 4'd5)});
                seq.push_back({8'h25, cw(2'b00, 1'b0, 1'b0, 4'd5, 5'd0, rs)});
                seq.push_back({8'h26, cw(2'b01, 1'b0, 1'b0, 4'd15, 5'd0, 4'd15)});
            end else begin
                seq.push_back({8'h22, cw(2'b00, 1'b0, 1'b0, rd, 5'd0, 4'd5)});
            end
        end
        for (int k = 0; k < seq.size(); k++) begin
            if (k > 0) @(negedge clock);
            vectors++;
            if (state !== seq[k][24:17] || ctrl !== seq[k][16:0] || halted !== 1'b0 ||
                icount !== exp_ic()) begin
                miscompares++;
                $display("FAIL seq ins=%h cyc=%0d: got state=%h ctrl=%h halted=%b icount=%h, want state=%h ctrl=%h halted=0 icount=%h",
                         ins, k, state, ctrl, halted, icount, seq[k][24:17], seq[k][16:0], exp_ic());
            end
            if (k == 0) begin
                I = ins;
                SZCy = fl;
                if (poke == 1) run = 1'b0;
            end
            if (k == 1 && poke == 2) begin run = 1'b1; step = 1'b1; end
            if (k == 2 && poke == 2) step = 1'b0;
        end
        retired++;
    endtask

    task automatic settle_halt(input string tag);
        @(negedge clock);
        vectors++;
        if (state !== 8'h00 || halted !== 1'b1 || ctrl !== IDLE || icount !== exp_ic()) begin
            miscompares++;
            $display("FAIL %s: got state=%h halted=%b ctrl=%h icount=%h, want state=00 halted=1 ctrl=%h icount=%h",
                     tag, state, halted, ctrl, icount, IDLE, exp_ic());
        end
    endtask

    task automatic start_step();
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        @(negedge clock);
    endtask

    function automatic logic [7:0] rand_ins();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v[7:4] == 4'h7) v = v ^ 8'h10;
        return v;
    endfunction

    task automatic run_burst(input int n, input logic [7:0] first, input int mode);
        logic [7:0] ins;
        start_run();
        for (int i = 0; i < n; i++) begin
            if (i == 0)        ins = first;
            else if (mode == 1) ins = {2'b00, 6'($urandom_range(0, 63))};
            else if (mode == 2) ins = {4'h4, 4'($urandom_range(0, 15))};
            else               ins = rand_ins();
            drive_instr(ins, 3'($urandom_range(0, 7)), (i == n - 1) ? 1 : 0);
            if (i != n - 1) @(negedge clock);
        end
        settle_halt("burst_end");
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; I = 8'h00; SZCy = 3'b000;
        retired = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        settle_halt("reset_state");
    endtask

    task automatic test_step_mov();
        start_step();
        drive_instr(8'h4E, 3'b000, 0);
        settle_halt("step_mov_halt");
        start_step();
        drive_instr(8'h5B, 3'b101, 0);
        settle_halt("step_in_halt");
        start_step();
        drive_instr(8'h63, 3'b010, 0);
        settle_halt("step_out_halt");
    endtask

    task automatic test_alu();
        run_burst(4, 8'h01, 1);
        run_burst(3, 8'h3D, 1);
    endtask

    task automatic test_mem();
        start_step();
        drive_instr(8'h92, 3'b000, 0);
        settle_halt("st_halt");
        start_step();
        drive_instr(8'h87, 3'b111, 0);
        settle_halt("ld_halt");
        start_step();
        drive_instr(8'hA4, 3'b000, 0);
        settle_halt("ldi_halt");
        start_step();
        drive_instr(8'hB9, 3'b000, 0);
        settle_halt("ldi11_halt");
    endtask

    task automatic test_jmp();
        logic [2:0] fl_tab [6] = '{3'b000, 3'b010, 3'b101, 3'b001, 3'b011, 3'b100};
        logic [7:0] in_tab [6] = '{8'hD0, 8'hD0, 8'hE0, 8'hE0, 8'hF0, 8'hF0};
        for (int i = 0; i < 6; i++) begin
            start_step();
            drive_instr(in_tab[i], fl_tab[i], 0);
            settle_halt("jmp_halt");
        end
        run_burst(6, 8'hC0, 0);
    endtask

    task automatic test_halt_instr();
        start_run();
        drive_instr(8'h01, 3'b000, 0);
        @(negedge clock);
        drive_instr(8'h70, 3'b000, 0);
        settle_halt("halt_instr");
        settle_halt("halt_instr_stays");
        run = 1'b0;
        settle_halt("halt_instr_run_low");
    endtask

    task automatic test_ignored_inputs();
        start_step();
        drive_instr(8'h49, 3'b000, 2);
        settle_halt("step_entry_ignores_run");
        settle_halt("no_restart_run_level");
        run = 1'b0;
        settle_halt("run_low");
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++)
            run_burst(int'($urandom_range(2, 10)), rand_ins(), 0);
    endtask

    task automatic test_reset_mid();
        start_step();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin I = 8'h85; SZCy = 3'b000; end
            @(negedge clock);
        end
        vectors++;
        if (state !== 8'h23) begin
            miscompares++;
            $display("FAIL ld_reach_L1: got state=%h, want 23", state);
        end
        #2 reset = 1'b1;
        retired = 0;
        #1;
        vectors++;
        if (state !== 8'h00 || halted !== 1'b1 || ctrl !== IDLE || icount !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_abort: got state=%h halted=%b ctrl=%h icount=%h, want 00 1 %h 00",
                     state, halted, ctrl, icount, IDLE);
        end
        @(negedge clock);
        reset = 1'b0;
        settle_halt("after_reset_mid");
    endtask

    task automatic test_icount_wrap();
        @(negedge clock);
        reset = 1'b1;
        retired = 0;
        @(negedge clock);
        reset = 1'b0;
        run_burst(256, 8'h40, 2);
        vectors++;
        if (icount !== exp_ic()) begin
            miscompares++;
            $display("FAIL icount_wrap: got icount=%h, want %h", icount, exp_ic());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        retired = 0;
        test_reset();
        test_step_mov();
        test_alu();
        test_mem();
        test_jmp();
        test_halt_instr();
        test_ignored_inputs();
        test_random();
        test_reset_mid();
        test_icount_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
